gen_frame_streamer: RTL and testbench

- Host-side driver for generator_mini. Buffers one input I/Q frame (I samples first, then Q), pulses the generator start, and streams the frame over the valid/ready input interface, mirroring each sample onto cond_in.
- Captures the OUT_CH*FRAME_LEN output samples into a result buffer and signals completion.
- This is the producer/consumer counterpart of the generator's stream ports; it replaces bench-driven stimulus in the system datapath.

---
 rtl/gen_stream_pkg.sv | 15 +
 rtl/gen_frame_buf.sv | 23 ++
 rtl/gen_frame_streamer.sv | 136 +++++++++++++
 tb/tb_gen_frame_streamer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/gen_stream_pkg.sv
// gen_stream_pkg: FSM state, frame-size constants and width helpers shared by the frame streamer.
package gen_stream_pkg;
   typedef enum logic [2:0] {IDLE, START, FEED, DRAIN, FIN} state_t;
   localparam int FRAME_LEN_DEF = 16;
   localparam int IN_CH_DEF = 2;
   localparam int OUT_CH_DEF = 2;
   localparam int IN_SAMPLES = IN_CH_DEF * FRAME_LEN_DEF;
   localparam int OUT_SAMPLES = OUT_CH_DEF * FRAME_LEN_DEF;
   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction
   function automatic int cnt_w(input int max_val);
      return (max_val > 1) ? $clog2(max_val + 1) : 1;
   endfunction
endpackage

// File: rtl/gen_frame_buf.sv
// gen_frame_buf: simple dual-port sync RAM, one write port and one registered read port.
module gen_frame_buf import gen_stream_pkg::*; #(
   parameter int DW = 16,
   parameter int DEPTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we,
   input  logic [addr_w(DEPTH)-1:0]   wa,
   input  logic [DW-1:0]              wd,
   input  logic [addr_w(DEPTH)-1:0]   ra,
   output logic [DW-1:0]              rd
);
   logic [DW-1:0] mem [DEPTH];
   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
   end
   // only the read register is reset so rd is 0 out of reset; contents are not
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd <= '0;
      else rd <= mem[ra];
   end
endmodule

// File: rtl/gen_frame_streamer.sv
// gen_frame_streamer: buffers one I/Q frame, streams it to generator_mini and captures the output frame.
// Define GEN_PERF_CNT_EN to build the perf_cycles busy-cycle counter; otherwise perf_cycles is 0.
module gen_frame_streamer import gen_stream_pkg::*; #(
   parameter int DATA_WIDTH = 16,
   parameter int FRAME_LEN = 16,
   parameter int IN_CH = 2,
   parameter int OUT_CH = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  wr_en,
   input  logic [addr_w(IN_CH*FRAME_LEN)-1:0]    wr_addr,
   input  logic [DATA_WIDTH-1:0]                 wr_data,
   input  logic                                  go,
   input  logic [addr_w(OUT_CH*FRAME_LEN)-1:0]   rd_addr,
   output logic [DATA_WIDTH-1:0]                 rd_data,
   output logic                                  gen_start,
   output logic [DATA_WIDTH-1:0]                 gen_data,
   output logic                                  gen_valid,
   input  logic                                  gen_ready,
   output logic [DATA_WIDTH-1:0]                 gen_cond,
   output logic                                  gen_cond_valid,
   input  logic [DATA_WIDTH-1:0]                 gen_out_data,
   input  logic                                  gen_out_valid,
   output logic                                  gen_out_ready,
   input  logic                                  gen_done,
   output logic                                  busy,
   output logic                                  frame_done,
   output logic                                  timeout_err,
   output logic [31:0]                           perf_cycles
);
   localparam int N_IN = IN_CH * FRAME_LEN;
   localparam int N_OUT = OUT_CH * FRAME_LEN;
   localparam int IAW = addr_w(N_IN);
   localparam int OAW = addr_w(N_OUT);
   localparam int ICW = cnt_w(N_IN);
   localparam int OCW = cnt_w(N_OUT);
   localparam int WDW = cnt_w(TIMEOUT_CYCLES);

   state_t state, state_nxt;
   logic [ICW-1:0] in_cnt, in_nxt;
   logic [OCW-1:0] out_cnt;
   logic [WDW-1:0] wd_cnt;
   logic [IAW-1:0] in_ra;
   logic [DATA_WIDTH-1:0] in_q;
   logic go_ok, streaming, in_hs, out_hs, in_last, out_last, wd_fire;
   logic unused_gen_done;

   assign go_ok = go && (state == IDLE);
   assign streaming = (state == FEED) || (state == DRAIN);
   assign gen_valid = (state == FEED);
   assign gen_data = gen_valid ? in_q : '0;
   assign gen_cond = gen_data;
   assign gen_cond_valid = gen_valid;
   assign gen_out_ready = streaming && (out_cnt < OCW'(N_OUT));
   assign gen_start = (state == START);
   assign frame_done = (state == FIN);
   assign busy = (state != IDLE);
   assign in_hs = gen_valid && gen_ready;
   assign out_hs = gen_out_valid && gen_out_ready;
   assign in_last = (in_cnt == ICW'(N_IN - 1));
   assign out_last = ((out_cnt + OCW'(out_hs)) == OCW'(N_OUT));
   assign wd_fire = streaming && !in_hs && !out_hs && (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));
   // read one sample ahead so the registered RAM output already holds the next sample after a handshake
   assign in_nxt = in_cnt + ICW'(in_hs);
   assign in_ra = (in_nxt < ICW'(N_IN)) ? in_nxt[IAW-1:0] : '0;

   gen_frame_buf #(.DW(DATA_WIDTH), .DEPTH(N_IN)) u_in_buf (
      .clk(clk),
      .rst(rst),
      .we(wr_en && (state == IDLE)),
      .wa(wr_addr),
      .wd(wr_data),
      .ra(in_ra),
      .rd(in_q)
   );

   gen_frame_buf #(.DW(DATA_WIDTH), .DEPTH(N_OUT)) u_out_buf (
      .clk(clk),
      .rst(rst),
      .we(out_hs),
      .wa(out_cnt[OAW-1:0]),
      .wd(gen_out_data),
      .ra(rd_addr),
      .rd(rd_data)
   );

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    state_nxt = go ? START : IDLE;
         START:   state_nxt = FEED;
         FEED:    state_nxt = wd_fire ? IDLE : (in_hs && in_last) ? DRAIN : FEED;
         DRAIN:   state_nxt = wd_fire ? IDLE : out_last ? FIN : DRAIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         in_cnt <= '0;
         out_cnt <= '0;
         wd_cnt <= '0;
         timeout_err <= 1'b0;
         unused_gen_done <= 1'b0;
      end else begin
         state <= state_nxt;
         if (go_ok) begin
            in_cnt <= '0;
            out_cnt <= '0;
            wd_cnt <= '0;
            timeout_err <= 1'b0;
            unused_gen_done <= 1'b0;
         end else begin
            if (in_hs) in_cnt <= in_cnt + 1'b1;
            if (out_hs) out_cnt <= out_cnt + 1'b1;
            if (streaming) wd_cnt <= (in_hs || out_hs) ? '0 : wd_cnt + 1'b1;
            if (wd_fire) timeout_err <= 1'b1;
            if (gen_done) unused_gen_done <= 1'b1;
         end
      end
   end

`ifdef GEN_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) perf_cycles <= '0;
      else if (go_ok) perf_cycles <= '0;
      else if (busy && (perf_cycles != '1)) perf_cycles <= perf_cycles + 1'b1;
   end
`else
   assign perf_cycles = '0;
`endif
endmodule

// File: tb/tb_gen_frame_streamer.sv
// tb_gen_frame_streamer: generator responder model plus scoreboard checking the frame streamer.
module tb_gen_frame_streamer;
   localparam int N_IN = 32;
   localparam int N_OUT = 32;

   logic clk = 0, rst = 1, wr_en = 0, go = 0, gen_ready = 0, gen_out_valid = 0, gen_done = 0;
   logic [4:0] wr_addr = '0, rd_addr = '0;
   logic [15:0] wr_data = '0, gen_out_data = '0;
   logic [15:0] rd_data, gen_data, gen_cond;
   logic gen_start, gen_valid, gen_cond_valid, gen_out_ready, busy, frame_done, timeout_err;
   logic [31:0] perf_cycles;

   gen_frame_streamer #(.TIMEOUT_CYCLES(64)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .go(go),
      .rd_addr(rd_addr), .rd_data(rd_data), .gen_start(gen_start), .gen_data(gen_data),
      .gen_valid(gen_valid), .gen_ready(gen_ready), .gen_cond(gen_cond),
      .gen_cond_valid(gen_cond_valid), .gen_out_data(gen_out_data),
      .gen_out_valid(gen_out_valid), .gen_out_ready(gen_out_ready), .gen_done(gen_done),
      .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err), .perf_cycles(perf_cycles)
   );

   always #5 clk = ~clk;

   typedef struct { logic [15:0] d; int due; } ev_t;
   ev_t echo_q[$];
   logic [15:0] sent_q[$];
   logic [15:0] in_mem [N_IN];
   int n_chk = 0, n_err = 0;
   int cyc = 0, in_idx = 0, n_done = 0, n_start = 0, busy_cyc = 0, out_in_feed = 0;
   int first_in = -1, last_in = 0, last_any = 0;
   int ready_mode = 0, stall_n = 0, echo_dly = 5, extra_n = 0;
   bit echo_en = 1, prev_stall = 0, prev_te = 0;
   logic [15:0] echo_x = '0, prev_data = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // generator model: ready pattern, echo of each input after echo_dly cycles, scoreboard
   always @(negedge clk) begin
      cyc++;
      chk("cond_mirror", {15'd0, gen_cond_valid, gen_cond}, {15'd0, gen_valid, gen_data});
      if (prev_stall && gen_valid) chk("stall_hold", gen_data, prev_data);
      if (gen_start) n_start++;
      if (busy) busy_cyc++;
      if (frame_done) begin
         n_done++;
         chk("done_in_cnt", in_idx, N_IN);
         chk("done_out_cnt", sent_q.size(), N_OUT);
      end
      if (timeout_err && !prev_te) begin
         chk("timeout_latency", cyc - last_any - 1, 64);
         chk("timeout_busy", busy, 0);
      end
      prev_te = timeout_err;
      gen_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? (cyc % 3 == 0) : (in_idx < stall_n);
      if (gen_valid && gen_ready) begin
         if (in_idx < N_IN) chk("in_order", gen_data, in_mem[in_idx]);
         else chk("extra_input", in_idx, N_IN - 1);
         if (first_in < 0) first_in = cyc;
         last_in = cyc;
         last_any = cyc;
         if (echo_en) echo_q.push_back('{gen_data ^ echo_x, cyc + echo_dly});
         in_idx++;
         if (echo_en && in_idx == N_IN)
            for (int i = 0; i < extra_n; i++) echo_q.push_back('{16'hBEEF, cyc + echo_dly + 1});
      end
      gen_out_valid = (echo_q.size() > 0) && (echo_q[0].due <= cyc);
      gen_out_data = gen_out_valid ? echo_q[0].d : '0;
      if (gen_out_valid && gen_out_ready) begin
         if (sent_q.size() >= N_OUT) chk("extra_output_accepted", sent_q.size(), N_OUT - 1);
         sent_q.push_back(echo_q[0].d);
         void'(echo_q.pop_front());
         last_any = cyc;
         if (gen_valid) out_in_feed++;
      end
      prev_stall = gen_valid && !gen_ready;
      prev_data = gen_data;
   end

   task automatic load(input int base, input int mul);
      for (int a = 0; a < N_IN; a++) begin
         @(posedge clk); #2;
         wr_en = 1; wr_addr = 5'(a); wr_data = 16'(base + mul * a); in_mem[a] = wr_data;
      end
      @(posedge clk); #2;
      wr_en = 0;
   endtask

   task automatic start_frame(input bit do_wr, input logic [4:0] a, input logic [15:0] d);
      @(posedge clk); #2;
      in_idx = 0; sent_q.delete(); echo_q.delete(); n_done = 0; n_start = 0;
      busy_cyc = 0; out_in_feed = 0; first_in = -1; prev_stall = 0;
      go = 1;
      if (do_wr) begin
         wr_en = 1; wr_addr = a; wr_data = d; in_mem[a] = d;
      end
      @(posedge clk); #2;
      go = 0; wr_en = 0;
      chk("go_clears_timeout", timeout_err, 0);
      chk("go_sets_busy", busy, 1);
   endtask

   task automatic wait_in(input int n);
      int i;
      for (i = 0; i < 2000; i++) begin
         @(posedge clk); #2;
         if (in_idx >= n) break;
      end
      if (i == 2000) chk("wait_in_bound", in_idx, n);
   endtask

   task automatic wait_end(input bit expect_to);
      int i;
      for (i = 0; i < 3000; i++) begin
         @(posedge clk); #2;
         if (!busy) break;
      end
      if (i == 3000) chk("wait_end_bound", busy, 0);
      chk("frame_done_count", n_done, expect_to ? 0 : 1);
      chk("gen_start_count", n_start, 1);
      chk("timeout_flag", timeout_err, 32'(expect_to));
`ifdef GEN_PERF_CNT_EN
      chk("perf_cycles", perf_cycles, busy_cyc);
`else
      chk("perf_cycles", perf_cycles, 0);
`endif
   endtask

   task automatic rd_chk(input logic [4:0] a, input logic [15:0] exp);
      @(posedge clk); #2;
      rd_addr = a;
      @(posedge clk); #2;
      chk("rd_data", rd_data, exp);
   endtask

   task automatic rd_all();
      for (int k = 0; k < N_OUT; k++) rd_chk(5'(k), sent_q[k]);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_outs", {gen_start, gen_valid, gen_cond_valid, gen_out_ready, busy, frame_done, timeout_err}, 0);
      chk("rst_data", {gen_data, gen_cond}, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_perf", perf_cycles, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #2;
      chk_reset_outputs();
      rst = 0;
      // back-to-back frame, echo after 5 cycles
      load(0, 10);
      ready_mode = 0; echo_en = 1; echo_dly = 5; echo_x = '0; extra_n = 0;
      start_frame(0, '0, '0);
      wait_end(0);
      chk("consecutive_inputs", last_in - first_in, N_IN - 1);
      for (int k = 0; k < N_OUT; k++) chk("model_pin", sent_q[k], 16'(10 * k));
      rd_chk(5'd5, 16'd50);
      rd_chk(5'd31, 16'd310);
      rd_all();
      // 1-of-3 ready with stalls; last sample written in the same cycle as go
      load(16'h100, 1);
      ready_mode = 1;
      start_frame(1, 5'd31, 16'h7ABC);
      wait_end(0);
      rd_all();
      // outputs interleaved during FEED plus extra outputs that must be refused
      ready_mode = 0; echo_dly = 2; echo_x = 16'h00FF; extra_n = 2;
      start_frame(0, '0, '0);
      wait_end(0);
      chk("out_during_feed", out_in_feed >= 3, 1);
      chk("extra_refused", echo_q.size(), 2);
      rd_chk(5'd2, 16'h01FD);
      rd_all();
      extra_n = 0; echo_x = '0; echo_dly = 5;
      // watchdog abort after 10 inputs, then a normal frame clears the flag
      ready_mode = 2; stall_n = 10; echo_en = 0;
      start_frame(0, '0, '0);
      wait_end(1);
      chk("timeout_in_cnt", in_idx, 10);
      ready_mode = 0; echo_en = 1;
      start_frame(0, '0, '0);
      wait_end(0);
      rd_all();
      // go and wr_en while busy are ignored
      ready_mode = 1;
      start_frame(0, '0, '0);
      wait_in(3);
      @(posedge clk); #2;
      go = 1; wr_en = 1; wr_addr = 5'd31; wr_data = 16'hDEAD;
      @(posedge clk); #2;
      go = 0; wr_en = 0;
      wait_end(0);
      chk("buf_unchanged", in_mem[31], 16'h7ABC);
      // asynchronous reset mid-FEED, then a full frame
      ready_mode = 0;
      start_frame(0, '0, '0);
      wait_in(10);
      rst = 1;
      #1;
      chk_reset_outputs();
      @(posedge clk); #2;
      rst = 0;
      echo_q.delete();
      chk("rst_no_done", n_done, 0);
      start_frame(0, '0, '0);
      wait_end(0);
      rd_all();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, errors=%0d", n_err);
      $fatal(1, "global timeout");
   end
endmodule
